// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: reset PC, NOP encoding and FSM states.
package fetch_unit_pkg;

  localparam logic [31:0] BASEADDR_DEF = 32'h0100_0000;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush, occupancy count and a registered head that holds its last
// value once the FIFO empties.
module fetch_fifo #(
  parameter int unsigned       DEPTH = 2,
  parameter int unsigned       WIDTH = 8,
  parameter logic [WIDTH-1:0]  INIT  = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr, wr_ptr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  // Head tracks the entry that will be at the front after this cycle's push/pop.
  always_comb begin
    head_d = head_q;
    if (!flush) begin
      if (do_pop) begin
        if (cnt > CW'(1))  head_d = mem[ptr_inc(rd_ptr)];
        else if (do_push)  head_d = din;
      end else if ((cnt == '0) && do_push) begin
        head_d = din;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      head_q <= INIT;
    end else begin
      head_q <= head_d;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (do_push) wr_ptr <= ptr_inc(wr_ptr);
        if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
        cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!flush && do_push) mem[wr_ptr] <= din;
  end

  assign head  = head_q;
  assign count = cnt;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, credit-limited in-order imem requests, response
// buffering to decode, and redirect handling that drains wrong-path responses.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned        AWIDTH   = 32,
  parameter int unsigned        DWIDTH   = 32,
  parameter logic [AWIDTH-1:0]  BASEADDR = AWIDTH'(BASEADDR_DEF),
  parameter int unsigned        DEPTH    = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  input  logic              ex_brtaken_i,
  input  logic              ex_jump_i,
  input  logic [AWIDTH-1:0] ex_target_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o
);

  localparam int unsigned       CW       = $clog2(DEPTH + 1);
  localparam logic [AWIDTH-1:0] RESET_PC = BASEADDR & ~AWIDTH'(3);

  fetch_state_e state_q, state_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW:0]       credit_used;
  logic [CW-1:0]     buf_count, tag_count;
  logic [AWIDTH-1:0] tag_head;
  logic [AWIDTH+DWIDTH-1:0] buf_head;
  logic redirect, req_fire, rsp_ok, handoff, buf_push, tag_push, tag_pop;

  assign redirect     = ex_brtaken_i | ex_jump_i;
  assign insn_valid_o = (buf_count != '0);
  assign handoff      = insn_valid_o & insn_ready_i;

  // A head leaving this cycle frees its slot, which sustains one fetch per cycle
  // against a 1-cycle memory without ever overfilling the buffer.
  assign credit_used = {1'b0, outst_q} + {1'b0, buf_count} - (CW+1)'(handoff);

  assign imem_req_valid_o = (state_q == RUN) && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;
  assign rsp_ok           = imem_rsp_valid_i && (outst_q != '0);
  assign outst_d          = outst_q + CW'(req_fire) - CW'(rsp_ok);

  assign tag_push = req_fire && !redirect;
  assign tag_pop  = rsp_ok && (tag_count != '0);
  assign buf_push = tag_pop && !redirect && (state_q == RUN);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect)      pc_d = ex_target_i & ~AWIDTH'(3);
    else if (req_fire) pc_d = pc_q + AWIDTH'(4);
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (redirect && (outst_d != '0)) state_d = DRAIN;
      DRAIN:   if (outst_d == '0) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      outst_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      outst_q <= outst_d;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AWIDTH),
    .INIT  (RESET_PC)
  ) u_tag_q (
    .clk   (clk),
    .rst   (reset),
    .push  (tag_push),
    .pop   (tag_pop),
    .flush (redirect),
    .din   (pc_q),
    .head  (tag_head),
    .count (tag_count)
  );

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (AWIDTH + DWIDTH),
    .INIT  ({RESET_PC, DWIDTH'(NOP_INSN)})
  ) u_insn_buf (
    .clk   (clk),
    .rst   (reset),
    .push  (buf_push),
    .pop   (handoff),
    .flush (redirect),
    .din   ({tag_head, imem_rsp_data_i}),
    .head  (buf_head),
    .count (buf_count)
  );

  assign pc_o   = buf_head[AWIDTH+DWIDTH-1:DWIDTH];
  assign insn_o = buf_head[DWIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a 1-cycle memory model feeds responses and queues the
// expected {pc, insn} handoffs, tracking redirects so wrong-path work is excluded.
module tb_fetch_unit;

  localparam logic [31:0] BASE = 32'h0100_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam int          DEPTH = 2;

  logic        clk;
  logic        reset;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        ex_brtaken_i;
  logic        ex_jump_i;
  logic [31:0] ex_target_i;
  logic        insn_valid_o;
  logic        insn_ready_i;
  logic [31:0] insn_o;
  logic [31:0] pc_o;

  fetch_unit #(
    .AWIDTH   (32),
    .DWIDTH   (32),
    .BASEADDR (32'h0100_0000),
    .DEPTH    (DEPTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .ex_brtaken_i     (ex_brtaken_i),
    .ex_jump_i        (ex_jump_i),
    .ex_target_i      (ex_target_i),
    .insn_valid_o     (insn_valid_o),
    .insn_ready_i     (insn_ready_i),
    .insn_o           (insn_o),
    .pc_o             (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          good;
  } pend_t;

  pend_t       mem_q[$];
  logic [63:0] sb[$];
  logic [31:0] ho_pc_q[$];
  int          ho_cyc_q[$];
  logic [31:0] exp_pc;
  logic [31:0] last_fire_addr;
  bit          rsp_en;
  int          cyc;
  int          n_fires;
  int          checks;
  int          failures;

  function automatic logic [31:0] insn_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction

  // One clock of stimulus: observe handshakes mid-cycle, then advance and present the next rsp.
  task automatic cycle();
    logic [63:0] got, want;
    pend_t       p;
    bit          redir;
    #1;
    redir = ex_brtaken_i | ex_jump_i;
    if (insn_valid_o && insn_ready_i) begin
      got = {pc_o, insn_o};
      ho_pc_q.push_back(pc_o);
      ho_cyc_q.push_back(cyc);
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL handoff_unexpected got=%h required=<none>", got);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          failures++;
          $display("FAIL handoff got=%h required=%h", got, want);
        end
      end
    end
    if (imem_req_valid_o && imem_req_ready_i) begin
      checks++;
      if (imem_req_addr_o !== exp_pc) begin
        failures++;
        $display("FAIL req_addr got=%h required=%h", imem_req_addr_o, exp_pc);
      end
      p.addr = imem_req_addr_o;
      p.good = 1'b1;
      mem_q.push_back(p);
      last_fire_addr = imem_req_addr_o;
      exp_pc = exp_pc + 32'd4;
      n_fires++;
    end
    if (imem_rsp_valid_i && mem_q.size() > 0) begin
      p = mem_q.pop_front();
      if (p.good && !redir) sb.push_back({p.addr, insn_of(p.addr)});
    end
    if (redir) begin
      sb.delete();
      foreach (mem_q[i]) mem_q[i].good = 1'b0;
      exp_pc = ex_target_i & ~32'd3;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rsp_en && mem_q.size() > 0) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = insn_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid_i = 1'b0;
      imem_rsp_data_i  = 32'hDEAD_DEAD;
    end
  endtask

  task automatic assert_reset();
    reset            = 1'b1;
    imem_req_ready_i = 1'b1;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'hDEAD_DEAD;
    ex_brtaken_i     = 1'b0;
    ex_jump_i        = 1'b0;
    ex_target_i      = 32'h0;
    insn_ready_i     = 1'b1;
    rsp_en           = 1'b1;
    mem_q.delete();
    sb.delete();
    ho_pc_q.delete();
    ho_cyc_q.delete();
    exp_pc = BASE;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_reset();
    reset   = 1'b0;
    cyc     = 0;
    n_fires = 0;
  endtask

  task automatic wait_handoffs(input int n, input int budget, input string what);
    int k;
    k = 0;
    while (ho_pc_q.size() < n && k < budget) begin
      cycle();
      k++;
    end
    checks++;
    if (ho_pc_q.size() < n) begin
      failures++;
      $display("FAIL %s_timeout got=%0d handoffs required=%0d", what, ho_pc_q.size(), n);
    end
  endtask

  task automatic check_reset_outputs(input string what);
    checks++;
    if (imem_req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_req_valid got=%b required=0", what, imem_req_valid_o);
    end
    checks++;
    if (insn_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL %s_insn_valid got=%b required=0", what, insn_valid_o);
    end
    checks++;
    if (insn_o !== NOP) begin
      failures++;
      $display("FAIL %s_insn got=%h required=%h", what, insn_o, NOP);
    end
    checks++;
    if (pc_o !== BASE) begin
      failures++;
      $display("FAIL %s_pc got=%h required=%h", what, pc_o, BASE);
    end
    checks++;
    if (imem_req_addr_o !== BASE) begin
      failures++;
      $display("FAIL %s_req_addr got=%h required=%h", what, imem_req_addr_o, BASE);
    end
  endtask

  task automatic test_reset();
    assert_reset();
    check_reset_outputs("reset");
    release_reset();
  endtask

  task automatic test_sequential();
    assert_reset();
    release_reset();
    repeat (8) cycle();
    checks++;
    if (ho_pc_q.size() < 3) begin
      failures++;
      $display("FAIL seq_count got=%0d required>=3", ho_pc_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ho_pc_q[i] !== BASE + 32'(4 * i) || ho_cyc_q[i] != 3 + i) begin
          failures++;
          $display("FAIL seq_pc%0d got=%h@%0d required=%h@%0d", i, ho_pc_q[i], ho_cyc_q[i],
                   BASE + 32'(4 * i), 3 + i);
        end
      end
    end
  endtask

  task automatic test_stall();
    assert_reset();
    insn_ready_i = 1'b0;
    release_reset();
    repeat (10) cycle();
    checks++;
    if (n_fires != DEPTH || imem_req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL stall_accepts got=%0d/%b required=%0d/0", n_fires, imem_req_valid_o, DEPTH);
    end
    insn_ready_i = 1'b1;
    wait_handoffs(8, 40, "stall");
    for (int i = 0; i < 8 && i < ho_pc_q.size(); i++) begin
      checks++;
      if (ho_pc_q[i] !== BASE + 32'(4 * i)) begin
        failures++;
        $display("FAIL stall_order%0d got=%h required=%h", i, ho_pc_q[i], BASE + 32'(4 * i));
      end
    end
  endtask

  task automatic test_branch_drain();
    assert_reset();
    rsp_en = 1'b0;
    release_reset();
    repeat (4) cycle();
    checks++;
    if (n_fires != 2 || mem_q.size() != 2) begin
      failures++;
      $display("FAIL br_outstanding got=%0d required=2", n_fires);
    end
    ex_brtaken_i = 1'b1;
    ex_target_i  = 32'h0100_0040;
    cycle();
    ex_brtaken_i = 1'b0;
    ex_target_i  = 32'hFFFF_FFFF;
    checks++;
    if (imem_req_valid_o !== 1'b0 || imem_req_addr_o !== 32'h0100_0040) begin
      failures++;
      $display("FAIL br_drain got=%b/%h required=0/01000040", imem_req_valid_o, imem_req_addr_o);
    end
    rsp_en = 1'b1;
    ho_pc_q.delete();
    wait_handoffs(1, 20, "br");
    checks++;
    if (ho_pc_q.size() > 0 && ho_pc_q[0] !== 32'h0100_0040) begin
      failures++;
      $display("FAIL br_first_pc got=%h required=01000040", ho_pc_q[0]);
    end
  endtask

  task automatic test_jump_align();
    assert_reset();
    release_reset();
    repeat (6) cycle();
    ex_jump_i   = 1'b1;
    ex_target_i = 32'h0100_0103;
    cycle();
    ex_jump_i   = 1'b0;
    ex_target_i = 32'h0;
    checks++;
    if (imem_req_addr_o !== 32'h0100_0100) begin
      failures++;
      $display("FAIL jump_addr got=%h required=01000100", imem_req_addr_o);
    end
    n_fires = 0;
    ho_pc_q.delete();
    for (int k = 0; k < 10 && n_fires == 0; k++) cycle();
    checks++;
    if (n_fires == 0 || last_fire_addr !== 32'h0100_0100) begin
      failures++;
      $display("FAIL jump_first_req got=%h(%0d) required=01000100", last_fire_addr, n_fires);
    end
    wait_handoffs(1, 20, "jump");
    checks++;
    if (ho_pc_q.size() > 0 && ho_pc_q[0] !== 32'h0100_0100) begin
      failures++;
      $display("FAIL jump_first_pc got=%h required=01000100", ho_pc_q[0]);
    end
  endtask

  task automatic test_redirect_rsp();
    logic [31:0] dropped;
    int          hits;
    assert_reset();
    release_reset();
    repeat (8) cycle();
    for (int k = 0; k < 20 && !imem_rsp_valid_i; k++) cycle();
    checks++;
    if (!imem_rsp_valid_i) begin
      failures++;
      $display("FAIL rr_no_rsp got=0 required=1");
    end else begin
      dropped     = mem_q[0].addr;
      ex_jump_i   = 1'b1;
      ex_target_i = 32'h0100_0200;
      cycle();
      ex_jump_i   = 1'b0;
      ho_pc_q.delete();
      repeat (20) cycle();
      hits = 0;
      foreach (ho_pc_q[i]) if (ho_pc_q[i] === dropped) hits++;
      checks++;
      if (hits != 0 || ho_pc_q.size() == 0 || ho_pc_q[0] !== 32'h0100_0200) begin
        failures++;
        $display("FAIL rr_dropped got=%0d hits/%0d handoffs required=0 hits first=01000200",
                 hits, ho_pc_q.size());
      end
    end
  endtask

  task automatic test_reset_in_drain();
    assert_reset();
    release_reset();
    repeat (8) cycle();
    rsp_en = 1'b0;
    repeat (3) cycle();
    ex_brtaken_i = 1'b1;
    ex_target_i  = 32'h0100_0080;
    cycle();
    ex_brtaken_i = 1'b0;
    checks++;
    if (imem_req_valid_o !== 1'b0 || insn_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rd_drain got=%b/%b required=0/0", imem_req_valid_o, insn_valid_o);
    end
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("rst_drain");
    assert_reset();
    release_reset();
    wait_handoffs(3, 20, "rst_drain");
    for (int i = 0; i < 3 && i < ho_pc_q.size(); i++) begin
      checks++;
      if (ho_pc_q[i] !== BASE + 32'(4 * i)) begin
        failures++;
        $display("FAIL rst_drain_pc%0d got=%h required=%h", i, ho_pc_q[i], BASE + 32'(4 * i));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit br;
    assert_reset();
    release_reset();
    for (int k = 0; k < 400; k++) begin
      insn_ready_i = ($urandom_range(0, 3) != 0);
      rsp_en       = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 15) == 0) begin
        br           = ($urandom_range(0, 1) == 1);
        ex_brtaken_i = br;
        ex_jump_i    = !br;
        ex_target_i  = BASE + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
      end
      cycle();
      ex_brtaken_i = 1'b0;
      ex_jump_i    = 1'b0;
    end
    rsp_en       = 1'b1;
    insn_ready_i = 1'b0;
    repeat (12) cycle();
    checks++;
    if (sb.size() != DEPTH || insn_valid_o !== 1'b1 || imem_req_valid_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_quiesce got=%0d/%b/%b required=%0d/1/0", sb.size(), insn_valid_o,
               imem_req_valid_o, DEPTH);
    end
    insn_ready_i = 1'b1;
    repeat (10) cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch_drain();
    test_jump_align();
    test_redirect_rsp();
    test_reset_in_drain();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog got=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
